// File: rtl/sar_pkg.sv
// Shared types and limits for the SAR conversion controller.
// Optional continuous-conversion mode is selected with SAR_CONT_EN.
package sar_pkg;

   typedef enum logic [1:0] {
      SAR_IDLE,
      SAR_SAMPLE,
      SAR_CONVERT
   } sar_state_e;

   localparam int unsigned SAR_WIDTH_MIN  = 2;
   localparam int unsigned SAR_WIDTH_MAX  = 16;
   localparam int unsigned SAR_SAMPLE_MIN = 1;
   localparam int unsigned SAR_SAMPLE_MAX = 15;

   // First trial code of a conversion: only the MSB of a width-bit code set.
   function automatic logic [SAR_WIDTH_MAX-1:0] sar_msb_code(input int unsigned width);
      logic [SAR_WIDTH_MAX-1:0] code;
      code = '0;
      code[width-1] = 1'b1;
      return code;
   endfunction

endpackage

// File: rtl/sar_ctrl_param_if.sv
// Handshake and analog-side signals of the SAR controller (cont exists only with SAR_CONT_EN).
interface sar_ctrl_param_if #(
   parameter int unsigned WIDTH = 12
);
   logic             start;
   logic             d;
   logic             sample;
   logic [WIDTH-1:0] dac_code;
   logic             busy;
   logic [WIDTH-1:0] result;
   logic             result_valid;
`ifdef SAR_CONT_EN
   logic             cont;

   modport master (
      input  start, d, cont,
      output sample, dac_code, busy, result, result_valid
   );
   modport slave (
      output start, d, cont,
      input  sample, dac_code, busy, result, result_valid
   );
`else
   modport master (
      input  start, d,
      output sample, dac_code, busy, result, result_valid
   );
   modport slave (
      output start, d,
      input  sample, dac_code, busy, result, result_valid
   );
`endif
endinterface

// File: rtl/sar_ctrl_param.sv
// Successive-approximation controller: sample phase, then one comparator bit per clock.
// SAR_CONT_EN adds a cont input that chains conversions without returning to idle.
module sar_ctrl_param
   import sar_pkg::*;
#(
   parameter int unsigned WIDTH         = 12,
   parameter int unsigned SAMPLE_CYCLES = 2
) (
   input logic              clk,
   input logic              reset,
   sar_ctrl_param_if.master bus
);

   localparam int unsigned KW = $clog2(WIDTH);

   typedef logic [WIDTH-1:0] code_t;

   if (WIDTH < SAR_WIDTH_MIN || WIDTH > SAR_WIDTH_MAX) begin : g_bad_width
      $error("sar_ctrl_param: WIDTH out of range");
   end
   if (SAMPLE_CYCLES < SAR_SAMPLE_MIN || SAMPLE_CYCLES > SAR_SAMPLE_MAX) begin : g_bad_sample
      $error("sar_ctrl_param: SAMPLE_CYCLES out of range");
   end

   sar_state_e    r_state, w_state;
   logic [3:0]    r_cnt, w_cnt;
   logic [KW-1:0] r_k, w_k;
   code_t         r_code, w_code;
   code_t         r_result, w_result;
   code_t         w_trial, w_msb;
   logic          r_sample, w_sample;
   logic          r_busy, w_busy;
   logic          r_valid, w_valid;
   logic          w_cont;

   assign w_msb = code_t'(sar_msb_code(WIDTH));

`ifdef SAR_CONT_EN
   assign w_cont = bus.cont;
`else
   assign w_cont = 1'b0;
`endif

   always_comb begin
      w_state  = r_state;
      w_cnt    = r_cnt;
      w_k      = r_k;
      w_code   = r_code;
      w_result = r_result;
      w_sample = r_sample;
      w_busy   = r_busy;
      w_valid  = 1'b0;

      // Resolve the bit under trial and raise the next one down.
      w_trial      = r_code;
      w_trial[r_k] = bus.d;
      if (r_k != '0) begin
         w_trial[r_k - 1'b1] = 1'b1;
      end

      unique case (r_state)
         SAR_IDLE: begin
            if (bus.start) begin
               w_state  = SAR_SAMPLE;
               w_sample = 1'b1;
               w_busy   = 1'b1;
               w_cnt    = 4'(SAMPLE_CYCLES - 1);
            end
         end
         SAR_SAMPLE: begin
            if (r_cnt == 4'd0) begin
               w_state  = SAR_CONVERT;
               w_sample = 1'b0;
               w_code   = w_msb;
               w_k      = KW'(WIDTH - 1);
            end else begin
               w_cnt = r_cnt - 4'd1;
            end
         end
         SAR_CONVERT: begin
            w_code = w_trial;
            if (r_k != '0) begin
               w_k = r_k - 1'b1;
            end else begin
               w_result = w_trial;
               w_valid  = 1'b1;
               w_code   = '0;
               if (w_cont) begin
                  w_state  = SAR_SAMPLE;
                  w_sample = 1'b1;
                  w_cnt    = 4'(SAMPLE_CYCLES - 1);
               end else begin
                  w_state = SAR_IDLE;
                  w_busy  = 1'b0;
               end
            end
         end
         default: begin
            w_state = SAR_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= SAR_IDLE;
         r_cnt    <= '0;
         r_k      <= '0;
         r_code   <= '0;
         r_result <= '0;
         r_sample <= 1'b0;
         r_busy   <= 1'b0;
         r_valid  <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_cnt    <= w_cnt;
         r_k      <= w_k;
         r_code   <= w_code;
         r_result <= w_result;
         r_sample <= w_sample;
         r_busy   <= w_busy;
         r_valid  <= w_valid;
      end
   end

   assign bus.sample       = r_sample;
   assign bus.dac_code     = r_code;
   assign bus.busy         = r_busy;
   assign bus.result       = r_result;
   assign bus.result_valid = r_valid;

endmodule

// File: tb/tb_sar_ctrl_param.sv
// Scoreboard bench for sar_ctrl_param: a 12-bit/2-sample instance and a 4-bit/1-sample instance.
module tb_sar_ctrl_param;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int chk = 0;
   int err = 0;

   sar_ctrl_param_if #(.WIDTH(12)) bus12 ();
   sar_ctrl_param_if #(.WIDTH(4))  bus4 ();

   sar_ctrl_param #(.WIDTH(12), .SAMPLE_CYCLES(2)) u_dut12 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus12.master)
   );

   sar_ctrl_param #(.WIDTH(4), .SAMPLE_CYCLES(1)) u_dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus4.master)
   );

`ifdef SAR_CONT_EN
   assign bus12.cont = 1'b0;
   assign bus4.cont  = 1'b0;
`endif

   // Comparator models: 0 = analog target, 1 = tied high, 2 = tied low.
   logic [11:0] target12;
   logic [1:0]  dmode;
   always_comb begin
      case (dmode)
         2'd0:    bus12.d = (target12 >= bus12.dac_code);
         2'd1:    bus12.d = 1'b1;
         default: bus12.d = 1'b0;
      endcase
   end
   always_comb bus4.d = (4'h9 >= bus4.dac_code);

   typedef struct {
      logic [15:0] res;
      int unsigned due;
   } exp_t;

   exp_t        q12[$];
   exp_t        q4[$];
   logic [11:0] qcode[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitors: pop an expectation whenever a result is presented.
   always @(negedge clk) begin
      exp_t e;
      if (bus12.result_valid === 1'b1) begin
         if (q12.size() == 0) begin
            chk++;
            err++;
            $display("FAIL unexpected_valid12 actual=%h required=none (cycle %0d)",
                     bus12.result, cyc);
         end else begin
            e = q12.pop_front();
            check("result12", 32'(bus12.result), 32'(e.res));
            check("valid_cycle12", cyc, e.due);
            check("busy_at_valid12", 32'(bus12.busy), 32'd0);
         end
      end
      if (bus12.busy === 1'b1 && bus12.sample === 1'b0 && qcode.size() > 0) begin
         check("dac_code12", 32'(bus12.dac_code), 32'(qcode.pop_front()));
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (bus4.result_valid === 1'b1) begin
         if (q4.size() == 0) begin
            chk++;
            err++;
            $display("FAIL unexpected_valid4 actual=%h required=none (cycle %0d)",
                     bus4.result, cyc);
         end else begin
            e = q4.pop_front();
            check("result4", 32'(bus4.result), 32'(e.res));
            check("valid_cycle4", cyc, e.due);
         end
      end
   end

   // Start pulse on the 12-bit instance; result appears 1+2+12 negedges later.
   task automatic start12(input bit push, input logic [11:0] res);
      exp_t e;
      @(negedge clk);
      bus12.start = 1'b1;
      if (push) begin
         e.res = 16'(res);
         e.due = cyc + 15;
         q12.push_back(e);
      end
      @(negedge clk);
      bus12.start = 1'b0;
   endtask

   task automatic wait_done12();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus12.busy === 1'b0) begin
            done = 1'b1;
            break;
         end
      end
      check("done_in_time12", 32'(done), 32'd1);
   endtask

   initial begin
      exp_t        e;
      logic [11:0] codes [12];
      int unsigned c;

      reset       = 1'b1;
      bus12.start = 1'b0;
      bus4.start  = 1'b0;
      dmode       = 2'd0;
      target12    = 12'hA5C;
      repeat (2) @(negedge clk);
      check("rst_sample", 32'(bus12.sample), 32'd0);
      check("rst_dac", 32'(bus12.dac_code), 32'd0);
      check("rst_busy", 32'(bus12.busy), 32'd0);
      check("rst_result", 32'(bus12.result), 32'd0);
      check("rst_valid", 32'(bus12.result_valid), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Directed trial sequence for target 0xA5C.
      codes = '{12'h800, 12'hC00, 12'hA00, 12'hB00, 12'hA80, 12'hA40,
                12'hA60, 12'hA50, 12'hA58, 12'hA5C, 12'hA5E, 12'hA5D};
      foreach (codes[i]) qcode.push_back(codes[i]);
      start12(1'b1, 12'hA5C);
      check("sample_1", 32'(bus12.sample), 32'd1);
      check("busy_1", 32'(bus12.busy), 32'd1);
      @(negedge clk);
      check("sample_2", 32'(bus12.sample), 32'd1);
      @(negedge clk);
      check("sample_3", 32'(bus12.sample), 32'd0);
      wait_done12();
      @(negedge clk);
      check("result_held", 32'(bus12.result), 32'hA5C);
      check("valid_one_cycle", 32'(bus12.result_valid), 32'd0);
      check("codes_consumed", 32'(qcode.size()), 32'd0);

      // Comparator tied high, then tied low.
      dmode = 2'd1;
      start12(1'b1, 12'hFFF);
      wait_done12();
      dmode = 2'd2;
      start12(1'b1, 12'h000);
      wait_done12();
      dmode = 2'd0;

      // Start pulses during CONVERT must be ignored.
      start12(1'b1, 12'hA5C);
      repeat (4) @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         bus12.start = ~bus12.start;
         @(negedge clk);
      end
      bus12.start = 1'b0;
      wait_done12();
      repeat (20) @(negedge clk);
      check("no_restart", 32'(bus12.busy), 32'd0);

      // Reset on the 5th CONVERT cycle aborts without a result.
      start12(1'b0, 12'h000);
      repeat (6) @(negedge clk);
      check("in_convert", 32'(bus12.dac_code[11]), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("abort_sample", 32'(bus12.sample), 32'd0);
      check("abort_dac", 32'(bus12.dac_code), 32'd0);
      check("abort_busy", 32'(bus12.busy), 32'd0);
      check("abort_result", 32'(bus12.result), 32'd0);
      check("abort_valid", 32'(bus12.result_valid), 32'd0);
      reset = 1'b0;
      start12(1'b1, 12'hA5C);
      wait_done12();

      // Back-to-back on the 4-bit instance: results every 6 cycles.
      @(negedge clk);
      bus4.start = 1'b1;
      c = cyc;
      for (int i = 0; i < 3; i++) begin
         e.res = 16'h9;
         e.due = c + 6 + 6 * i;
         q4.push_back(e);
      end
      repeat (18) @(negedge clk);
      bus4.start = 1'b0;
      repeat (10) @(negedge clk);
      check("b2b_idle4", 32'(bus4.busy), 32'd0);

      repeat (3) @(negedge clk);
      check("q12_drained", 32'(q12.size()), 32'd0);
      check("q4_drained", 32'(q4.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", chk, err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
